// File: rtl/div_pkg.sv
// Shared types and sizing for the restoring shift-subtract divider controller.
package div_pkg;

    localparam int DIV_WIDTH = 10;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter: synchronous clear, count enable, terminal flag at WIDTH-1.
// Holds at WIDTH so a stray enable can never wrap it.
module div_iter_counter #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_W'(WIDTH))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencing FSM for the restoring shift-subtract divider (IDLE/LOAD/ITER/DONE).
// Optional divide-by-zero short cut is enabled with `define DIV_ZERO_CHECK_EN.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter  int WIDTH = DIV_WIDTH,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic             sub_neg,
`ifdef DIV_ZERO_CHECK_EN
    input  logic             divisor_zero,
    output logic             err,
`endif
    output logic             ld_operands,
    output logic             loading_done,
    output logic             shift,
    output logic             ld_sub,
    output logic             q_bit,
    output logic [CNT_W-1:0] iter,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    div_state_e state_q, state_d;
    logic       cnt_clr, cnt_en, cnt_last;
    logic       zero_req;

`ifdef DIV_ZERO_CHECK_EN
    logic err_q;

    assign zero_req = divisor_zero;

    // Flag is refreshed on every accepted start and then held for the host.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state_q == IDLE) && start) begin
            err_q <= divisor_zero;
        end
    end

    assign err = err_q;
`else
    assign zero_req = 1'b0;
`endif

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = zero_req ? DONE : LOAD;
            LOAD:    state_d = ITER;
            ITER:    if (cnt_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore decode; only the accumulator steer looks at the live subtractor sign.
    always_comb begin
        ld_operands  = 1'b0;
        loading_done = 1'b0;
        shift        = 1'b0;
        ld_sub       = 1'b0;
        q_bit        = 1'b0;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        case (state_q)
            IDLE: ready = 1'b1;
            LOAD: begin
                ld_operands = 1'b1;
                busy        = 1'b1;
                cnt_clr     = 1'b1;
            end
            ITER: begin
                loading_done = 1'b1;
                shift        = 1'b1;
                busy         = 1'b1;
                cnt_en       = 1'b1;
                ld_sub       = ~sub_neg;
                q_bit        = ~sub_neg;
            end
            DONE:    done = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    div_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clock (clock),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (iter),
        .last  (cnt_last)
    );

    assign state_dbg = state_q;

endmodule
